payload_decoder: RTL and testbench

PAYLOAD_DECODER -- requirements
Module: payload_decoder

---
 rtl/aqueduct_pcs_pkg.sv | 57 +++++
 rtl/axis_beat_fifo.sv | 72 +++++++
 rtl/payload_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_payload_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aqueduct_pcs_pkg.sv
// Shared definitions for the aqueduct PCS encoder and decoder.
//   - Sync header values (H_DATA, H_CTRL).
//   - Control block type codes carried in payload[63:56] of an H_CTRL block.
//   - Decoder state encoding and the AXI-Stream beat record.
//   - Byte-lane helpers. Byte 0 is data[63:56] and pairs with keep[7].
package aqueduct_pcs_pkg;

  localparam logic [1:0] H_DATA = 2'b01;
  localparam logic [1:0] H_CTRL = 2'b10;

  // Control block type codes (payload[63:56]).
  localparam logic [7:0] T_IDLE  = 8'h1E;
  localparam logic [7:0] T_S1    = 8'h11;
  localparam logic [7:0] T_S2    = 8'h12;
  localparam logic [7:0] T_S3    = 8'h13;
  localparam logic [7:0] T_S4    = 8'h14;
  localparam logic [7:0] T_S5    = 8'h15;
  localparam logic [7:0] T_T0    = 8'h20;
  localparam logic [7:0] T_T1    = 8'h21;
  localparam logic [7:0] T_T2    = 8'h22;
  localparam logic [7:0] T_T3    = 8'h23;
  localparam logic [7:0] T_T4    = 8'h24;
  localparam logic [7:0] T_T5    = 8'h25;
  localparam logic [7:0] T_T6    = 8'h26;
  localparam logic [7:0] T_T7    = 8'h27;
  localparam logic [7:0] T_PAUSE = 8'h4B;
  localparam logic [7:0] T_ERROR = 8'hFE;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } dec_state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  user;
    logic [7:0]  dest;
    logic        last;
  } beat_t;

  // keep with the n_bytes most significant bits set (n_bytes = 0..8).
  function automatic logic [7:0] keep_msb(input logic [3:0] n_bytes);
    return ~(8'hff >> n_bytes);
  endfunction

  // Zero every byte lane whose keep bit is clear.
  function automatic logic [63:0] mask_bytes(input logic [63:0] data,
                                             input logic [7:0]  keep);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = data[8*i +: 8] & {8{keep[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_beat_fifo.sv
// Beat queue between the decoder and the AXI-Stream output.
// Dual-write, single-read, first-word fall-through, count-based empty/free.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   wr0_en_i/wr0_data_i        first write of the cycle (lands first)
//   wr1_en_i/wr1_data_i        second write of the cycle (lands after wr0)
//   rd_en_i                    pop the head (ignored while empty)
//   rd_data_o                  head entry, valid whenever empty_o = 0
//   empty_o                    queue holds no entries
//   free_o                     free entries before this cycle's pop
// The writer must never request more writes than free_o allows.
module axis_beat_fifo
  import aqueduct_pcs_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr0_en_i,
  input  beat_t                      wr0_data_i,
  input  logic                       wr1_en_i,
  input  beat_t                      wr1_data_i,
  input  logic                       rd_en_i,
  output beat_t                      rd_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     free_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  beat_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr1_addr;
  logic [CW-1:0] count_q, count_d;
  logic          do_rd;

  assign empty_o   = (count_q == '0);
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign free_o    = CW'(DEPTH) - count_q;

  // wr1 lands behind wr0 when both fire in the same cycle.
  assign wr1_addr = wr0_en_i ? wr_ptr_q + AW'(1) : wr_ptr_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr0_en_i) + AW'(wr1_en_i);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(do_rd);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-empty count.
  always_ff @(posedge clk_i) begin
    if (wr0_en_i) mem_q[wr_ptr_q] <= wr0_data_i;
    if (wr1_en_i) mem_q[wr1_addr] <= wr1_data_i;
  end

endmodule

// File: rtl/payload_decoder.sv
// Recovers an AXI-Stream from 64-bit encoded blocks (2-bit sync header).
// Frames open with a start block (T_S1..T_S4 are single-beat frames, T_S5
// opens a multi-block frame), continue with H_DATA blocks and close with a
// terminate block T_T0..T_T7. Inside a frame the decoder always carries five
// bytes, so each data block emits one full beat and refills the carry.
// Ports:
//   clk_in, rst_n_in             clock, asynchronous active-low reset
//   payload_in, header_in        received block; block_valid_in qualifies it
//   m_axis_*                     recovered stream (tdata byte 0 = [63:56])
//   remote_pause_out             last pause state seen
//   pause_dest_out               channel the pause applies to
//   frame_error_out              one-cycle pulse on a protocol error
//   overflow_out                 one-cycle pulse when a beat write is dropped
//   dbg_state_out                decoder state (0 = IDLE, 1 = IN_FRAME)
// Handshake: a beat transfers on a rising edge where m_axis_tvalid and
// m_axis_tready are both 1; while tvalid=1 and tready=0 every m_axis field
// holds its value, and tvalid never drops without a transfer.
module payload_decoder
  import aqueduct_pcs_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [63:0] payload_in,
  input  logic [1:0]  header_in,
  input  logic        block_valid_in,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic [7:0]  m_axis_tuser,
  output logic [7:0]  m_axis_tdest,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        remote_pause_out,
  output logic [7:0]  pause_dest_out,
  output logic        frame_error_out,
  output logic        overflow_out,
  output logic        dbg_state_out
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  dec_state_e  state_q, state_d;
  logic [39:0] carry_q, carry_d;
  logic [7:0]  user_q, user_d;
  logic [7:0]  dest_q, dest_d;
  logic        pause_q, pause_d;
  logic [7:0]  pause_dest_q, pause_dest_d;
  logic        ferr_q, ferr_d;
  logic        ovf_q, ovf_d;

  beat_t       beat0, beat1;
  logic        want0, want1;
  logic        drop_write;
  logic [1:0]  n_req;

  beat_t       head;
  logic        fifo_empty;
  logic [CW-1:0] fifo_free;

  logic [7:0]  blk_type;
  logic [3:0]  start_len;
  logic [2:0]  term_k;
  logic [3:0]  term_total;
  logic        pause_ones, pause_zeros;

  assign blk_type    = payload_in[63:56];
  assign start_len   = 4'(blk_type - T_S1) + 4'd1;
  assign term_k      = 3'(blk_type - T_T0);
  assign term_total  = 4'd5 + {1'b0, term_k};
  assign pause_ones  = &payload_in[39:8];
  assign pause_zeros = ~|payload_in[39:8];

  always_comb begin
    state_d      = state_q;
    carry_d      = carry_q;
    user_d       = user_q;
    dest_d       = dest_q;
    pause_d      = pause_q;
    pause_dest_d = pause_dest_q;
    ferr_d       = 1'b0;
    beat0        = '0;
    beat1        = '0;
    want0        = 1'b0;
    want1        = 1'b0;

    if (block_valid_in) begin
      if (header_in == H_DATA) begin
        if (state_q == ST_IN_FRAME) begin
          beat0.data = {carry_q, payload_in[63:40]};
          beat0.keep = 8'hff;
          beat0.user = user_q;
          beat0.dest = dest_q;
          want0      = 1'b1;
          carry_d    = payload_in[39:0];
        end else begin
          ferr_d = 1'b1;
        end
      end else if (header_in == H_CTRL) begin
        if (blk_type == T_IDLE) begin
          // Filler: legal anywhere, touches nothing.
        end else if (blk_type == T_PAUSE) begin
          // A malformed pause flags an error but leaves the frame alone.
          pause_dest_d = payload_in[55:48];
          if (pause_ones)       pause_d = 1'b1;
          else if (pause_zeros) pause_d = 1'b0;
          else                  ferr_d  = 1'b1;
        end else if (blk_type inside {[T_S1:T_S4]}) begin
          // A start inside a frame aborts the old frame, then is honoured.
          if (state_q == ST_IN_FRAME) ferr_d = 1'b1;
          beat0.keep = keep_msb(start_len);
          beat0.data = mask_bytes({payload_in[39:0], 24'h0}, beat0.keep);
          beat0.user = payload_in[55:48];
          beat0.dest = payload_in[47:40];
          beat0.last = 1'b1;
          want0      = 1'b1;
          carry_d    = '0;
          state_d    = ST_IDLE;
        end else if (blk_type == T_S5) begin
          if (state_q == ST_IN_FRAME) ferr_d = 1'b1;
          user_d  = payload_in[55:48];
          dest_d  = payload_in[47:40];
          carry_d = payload_in[39:0];
          state_d = ST_IN_FRAME;
        end else if (blk_type inside {[T_T0:T_T7]}) begin
          if (state_q == ST_IN_FRAME) begin
            beat0.user = user_q;
            beat0.dest = dest_q;
            want0      = 1'b1;
            if (term_k <= 3'd3) begin
              // Carry plus up to three tail bytes fit in one beat.
              beat0.keep = keep_msb(term_total);
              beat0.data = mask_bytes({carry_q, payload_in[55:32]}, beat0.keep);
              beat0.last = 1'b1;
            end else begin
              // Nine or more bytes: one full beat, then the k-3 remainder.
              beat0.keep = 8'hff;
              beat0.data = {carry_q, payload_in[55:32]};
              beat1.keep = keep_msb(4'({1'b0, term_k}) - 4'd3);
              beat1.data = mask_bytes({payload_in[31:0], 32'h0}, beat1.keep);
              beat1.user = user_q;
              beat1.dest = dest_q;
              beat1.last = 1'b1;
              want1      = 1'b1;
            end
            carry_d = '0;
            state_d = ST_IDLE;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          // T_ERROR and any unknown type.
          ferr_d  = 1'b1;
          carry_d = '0;
          state_d = ST_IDLE;
        end
      end else begin
        // Invalid sync header 2'b00 / 2'b11.
        ferr_d  = 1'b1;
        carry_d = '0;
        state_d = ST_IDLE;
      end
    end
  end

  // Free space is judged before this cycle's pop, and a two-beat write is
  // all-or-nothing so a frame tail is never split across a drop.
  always_comb begin
    n_req      = {1'b0, want0} + {1'b0, want1};
    drop_write = (CW'(n_req) > fifo_free);
    ovf_d      = drop_write;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      carry_q      <= '0;
      user_q       <= '0;
      dest_q       <= '0;
      pause_q      <= 1'b0;
      pause_dest_q <= '0;
      ferr_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      carry_q      <= carry_d;
      user_q       <= user_d;
      dest_q       <= dest_d;
      pause_q      <= pause_d;
      pause_dest_q <= pause_dest_d;
      ferr_q       <= ferr_d;
      ovf_q        <= ovf_d;
    end
  end

  axis_beat_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_in),
    .rst_ni     (rst_n_in),
    .wr0_en_i   (want0 && !drop_write),
    .wr0_data_i (beat0),
    .wr1_en_i   (want1 && !drop_write),
    .wr1_data_i (beat1),
    .rd_en_i    (m_axis_tready),
    .rd_data_o  (head),
    .empty_o    (fifo_empty),
    .free_o     (fifo_free)
  );

  // Fields are forced to zero while nothing is presented (including reset).
  assign m_axis_tvalid    = !fifo_empty;
  assign m_axis_tdata     = m_axis_tvalid ? head.data : '0;
  assign m_axis_tkeep     = m_axis_tvalid ? head.keep : '0;
  assign m_axis_tuser     = m_axis_tvalid ? head.user : '0;
  assign m_axis_tdest     = m_axis_tvalid ? head.dest : '0;
  assign m_axis_tlast     = m_axis_tvalid && head.last;
  assign remote_pause_out = pause_q;
  assign pause_dest_out   = pause_dest_q;
  assign frame_error_out  = ferr_q;
  assign overflow_out     = ovf_q;
  assign dbg_state_out    = state_q;

endmodule

// File: tb/tb_payload_decoder.sv
module tb_payload_decoder;
  import aqueduct_pcs_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic [63:0] payload_in = '0;
  logic [1:0]  header_in = '0;
  logic        block_valid_in = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep, m_axis_tuser, m_axis_tdest;
  logic        m_axis_tlast, m_axis_tvalid;
  logic        remote_pause_out;
  logic [7:0]  pause_dest_out;
  logic        frame_error_out, overflow_out, dbg_state_out;

  always #5 clk_in = ~clk_in;

  payload_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .payload_in       (payload_in),
    .header_in        (header_in),
    .block_valid_in   (block_valid_in),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tuser     (m_axis_tuser),
    .m_axis_tdest     (m_axis_tdest),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .remote_pause_out (remote_pause_out),
    .pause_dest_out   (pause_dest_out),
    .frame_error_out  (frame_error_out),
    .overflow_out     (overflow_out),
    .dbg_state_out    (dbg_state_out)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a byte stream; beats are cut from it 8 bytes at a time.
  logic [88:0] exp_q[$];
  logic [88:0] nb_q[$];
  logic [7:0]  m_bytes[$];
  bit          m_in_frame = 0;
  logic [7:0]  m_user = '0, m_dest = '0;
  logic        exp_ferr = 0, exp_ovf = 0, exp_pause = 0;
  logic [7:0]  exp_pdest = '0;

  task automatic emit_beat(input int n, input bit last, input logic [7:0] u, input logic [7:0] d);
    logic [63:0] data;
    logic [7:0]  keep;
    data = '0;
    keep = '0;
    for (int i = 0; i < n; i++) begin
      data[63-8*i -: 8] = m_bytes.pop_front();
      keep[7-i] = 1'b1;
    end
    nb_q.push_back({data, keep, u, d, last});
  endtask

  task automatic model_step();
    logic [7:0] t;
    int         free;
    bit         err, drop, ovf;
    err  = 0;
    drop = 0;
    ovf  = 0;
    nb_q.delete();
    free = DEPTH - exp_q.size();
    if (m_axis_tready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (block_valid_in) begin
      t = payload_in[63:56];
      if (header_in == H_DATA) begin
        if (m_in_frame) begin
          for (int i = 0; i < 8; i++) m_bytes.push_back(payload_in[63-8*i -: 8]);
          emit_beat(8, 0, m_user, m_dest);
        end else err = 1;
      end else if (header_in == H_CTRL) begin
        if (t == T_IDLE) begin
        end else if (t == T_PAUSE) begin
          exp_pdest = payload_in[55:48];
          if (payload_in[39:8] == 32'hFFFFFFFF) exp_pause = 1;
          else if (payload_in[39:8] == 32'h0)   exp_pause = 0;
          else err = 1;
        end else if (t >= T_S1 && t <= T_S5) begin
          if (m_in_frame) err = 1;
          m_bytes.delete();
          for (int i = 0; i < int'(t - T_S1) + 1; i++) m_bytes.push_back(payload_in[39-8*i -: 8]);
          if (t == T_S5) begin
            m_user = payload_in[55:48];
            m_dest = payload_in[47:40];
            m_in_frame = 1;
          end else begin
            emit_beat(m_bytes.size(), 1, payload_in[55:48], payload_in[47:40]);
            m_in_frame = 0;
          end
        end else if (t >= T_T0 && t <= T_T7) begin
          if (m_in_frame) begin
            for (int i = 0; i < int'(t - T_T0); i++) m_bytes.push_back(payload_in[55-8*i -: 8]);
            while (m_bytes.size() > 8) emit_beat(8, 0, m_user, m_dest);
            emit_beat(m_bytes.size(), 1, m_user, m_dest);
            m_in_frame = 0;
          end else err = 1;
        end else begin
          err = 1;
          drop = 1;
        end
      end else begin
        err = 1;
        drop = 1;
      end
    end
    if (drop) begin
      m_in_frame = 0;
      m_bytes.delete();
    end
    if (nb_q.size() > free) ovf = 1;
    else foreach (nb_q[i]) exp_q.push_back(nb_q[i]);
    exp_ferr = err;
    exp_ovf  = ovf;
  endtask

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      exp_q.delete();
      m_bytes.delete();
      m_in_frame = 0;
      exp_ferr = 0;
      exp_ovf = 0;
      exp_pause = 0;
      exp_pdest = '0;
    end else begin
      model_step();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk_in) begin
    chk("tvalid", m_axis_tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0)
      chk("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tdest, m_axis_tlast}, exp_q[0]);
    chk("frame_error", frame_error_out, exp_ferr);
    chk("overflow", overflow_out, exp_ovf);
    chk("remote_pause", remote_pause_out, exp_pause);
    chk("pause_dest", pause_dest_out, exp_pdest);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] h, input logic [63:0] p);
    @(negedge clk_in);
    header_in      = h;
    payload_in     = p;
    block_valid_in = 1'b1;
  endtask

  task automatic idle_cyc();
    @(negedge clk_in);
    block_valid_in = 1'b0;
  endtask

  task automatic pop_one();
    m_axis_tready = 1'b1;
    @(negedge clk_in);
    m_axis_tready = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [63:0] d, input logic [7:0] k, input logic l);
    chk({name, " tvalid"}, m_axis_tvalid, 1'b1);
    chk({name, " tdata"}, m_axis_tdata, d);
    chk({name, " tkeep"}, m_axis_tkeep, k);
    chk({name, " tlast"}, m_axis_tlast, l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    #1 rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("reset tvalid", m_axis_tvalid, 1'b0);
    chk("reset tdata", m_axis_tdata, 64'h0);
    #2 rst_n_in = 1'b1;

    // S2 single-beat frame; trailing payload bytes must be masked off.
    send(H_CTRL, {T_S2, 8'h03, 8'h07, 16'hAABB, 24'hCCDDEE});
    idle_cyc();
    chk_head("s2", 64'hAABB000000000000, 8'hc0, 1'b1);
    chk("s2 tuser", m_axis_tuser, 8'h03);
    chk("s2 tdest", m_axis_tdest, 8'h07);
    pop_one();
    chk("s2 drained", m_axis_tvalid, 1'b0);

    // S5 + DATA + T7 -> three beats, the last two from one block.
    send(H_CTRL, {T_S5, 8'h11, 8'h22, 40'h0102030405});
    send(H_DATA, 64'h060708090A0B0C0D);
    send(H_CTRL, {T_T7, 56'h0E0F1011121314});
    idle_cyc();
    chk_head("t7 b0", 64'h0102030405060708, 8'hff, 1'b0);
    pop_one();
    chk_head("t7 b1", 64'h090A0B0C0D0E0F10, 8'hff, 1'b0);
    pop_one();
    chk_head("t7 b2", 64'h1112131400000000, 8'hf0, 1'b1);
    pop_one();

    // IDLE and PAUSE mid-frame leave the frame intact.
    send(H_CTRL, {T_S5, 8'h05, 8'h06, 40'hA1A2A3A4A5});
    send(H_CTRL, {T_IDLE, 56'h0});
    send(H_CTRL, {T_PAUSE, 8'h02, 8'h00, 32'hFFFFFFFF, 8'h00});
    send(H_DATA, 64'hB1B2B3B4B5B6B7B8);
    send(H_CTRL, {T_T0, 56'h0});
    idle_cyc();
    chk("pause state", remote_pause_out, 1'b1);
    chk("pause dest", pause_dest_out, 8'h02);
    chk_head("p b0", 64'hA1A2A3A4A5B1B2B3, 8'hff, 1'b0);
    pop_one();
    chk_head("p b1", 64'hB4B5B6B7B8000000, 8'hf8, 1'b1);
    pop_one();

    // DATA in IDLE, then a bad header: two error pulses, no beats.
    send(H_DATA, 64'h1122334455667788);
    send(2'b11, 64'h0);
    chk("data-in-idle ferr", frame_error_out, 1'b1);
    idle_cyc();
    chk("hdr11 ferr", frame_error_out, 1'b1);
    idle_cyc();
    chk("ferr cleared", frame_error_out, 1'b0);
    chk("no beats", m_axis_tvalid, 1'b0);

    // Fill the queue with 3 S1 beats, then S5+T7 overflows.
    send(H_CTRL, {T_S1, 16'h0, 8'hC1, 32'h0});
    send(H_CTRL, {T_S1, 16'h0, 8'hC2, 32'h0});
    send(H_CTRL, {T_S1, 16'h0, 8'hC3, 32'h0});
    send(H_CTRL, {T_S5, 16'h0, 40'h0102030405});
    send(H_CTRL, {T_T7, 56'h0E0F1011121314});
    idle_cyc();
    chk("ovf pulse", overflow_out, 1'b1);
    idle_cyc();
    chk("ovf one cycle", overflow_out, 1'b0);
    chk_head("ovf d0", 64'hC100000000000000, 8'h80, 1'b1);
    pop_one();
    chk_head("ovf d1", 64'hC200000000000000, 8'h80, 1'b1);
    pop_one();
    chk_head("ovf d2", 64'hC300000000000000, 8'h80, 1'b1);
    pop_one();
    chk("ovf drained", m_axis_tvalid, 1'b0);

    // Reset mid-frame with a beat queued and pause asserted.
    send(H_CTRL, {T_S1, 8'h44, 8'h55, 8'hEE, 32'h0});
    send(H_CTRL, {T_S5, 16'h0, 40'h0102030405});
    idle_cyc();
    #2 rst_n_in = 1'b0;
    #1;
    chk("rst tvalid", m_axis_tvalid, 1'b0);
    chk("rst tdata", m_axis_tdata, 64'h0);
    chk("rst tkeep", m_axis_tkeep, 8'h0);
    chk("rst tuser", m_axis_tuser, 8'h0);
    chk("rst tdest", m_axis_tdest, 8'h0);
    chk("rst tlast", m_axis_tlast, 1'b0);
    chk("rst pause", remote_pause_out, 1'b0);
    chk("rst pdest", pause_dest_out, 8'h0);
    @(negedge clk_in);
    #2 rst_n_in = 1'b1;
    send(H_CTRL, {T_T3, 56'h11223344556677});
    idle_cyc();
    chk("t3 after rst ferr", frame_error_out, 1'b1);
    chk("t3 after rst no beat", m_axis_tvalid, 1'b0);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_in);
      m_axis_tready  = ($urandom_range(0, 3) != 0);
      block_valid_in = ($urandom_range(0, 4) != 0);
      payload_in     = {$urandom, $urandom};
      header_in      = H_CTRL;
      r = $urandom_range(0, 99);
      if (r < 30)      header_in = H_DATA;
      else if (r < 42) payload_in[63:56] = T_S5;
      else if (r < 47) payload_in[63:56] = T_S1 + 8'($urandom_range(0, 3));
      else if (r < 67) payload_in[63:56] = T_T0 + 8'($urandom_range(0, 7));
      else if (r < 73) payload_in[63:56] = T_IDLE;
      else if (r < 82) begin
        payload_in[63:56] = T_PAUSE;
        case ($urandom_range(0, 2))
          0: payload_in[39:8] = 32'hFFFFFFFF;
          1: payload_in[39:8] = 32'h0;
          default: ;
        endcase
      end
      else if (r < 86) payload_in[63:56] = T_ERROR;
      else if (r < 89) payload_in[63:56] = 8'h77;
      else if (r < 92) header_in = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      else             header_in = H_DATA;
    end

    @(negedge clk_in);
    block_valid_in = 1'b0;
    m_axis_tready  = 1'b1;
    repeat (10) @(negedge clk_in);
    chk("final empty", m_axis_tvalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
